// File: rtl/johnson_decoder_monitor.sv
`default_nettype none
// ============================================================================
// johnson_decoder_monitor : decodes Johnson code words to a binary index,
// flags illegal/out-of-sequence codes, tracks lock and counts sequence wraps.
// Optional macro JC_STALL_TOL_EN: a repeated legal code counts as in-sequence.
// Rev 1.0
// ============================================================================
module johnson_decoder_monitor #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  parameter int WRAP_W   = 8
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   valid_in,
  input  logic [N-1:0]           jc_in,
  output logic [$clog2(2*N)-1:0] bin_out,
  output logic                   bin_valid,
  output logic                   illegal,
  output logic                   seq_err,
  output logic                   locked,
  output logic [WRAP_W-1:0]      wrap_cnt
);

  localparam int            BW       = $clog2(2*N);
  localparam int            SW       = $clog2(LOCK_CNT + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(2*N - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACKING = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  state_e        state_q;
  logic [SW-1:0] streak_q;
  logic [BW-1:0] prev_q;

  logic          w_legal;
  logic [BW-1:0] w_idx;
  logic [BW-1:0] w_next_idx;
  logic          w_succ;
  logic          w_rep;

  // A legal Johnson word has at most one 0/1 boundary between adjacent bits;
  // exactly 2N words satisfy that, which is the whole code set.
  always_comb begin
    int ones;
    int edges;
    ones  = 0;
    edges = 0;
    for (int b = 0; b < N; b++) begin
      ones += int'(jc_in[b]);
    end
    for (int b = 1; b < N; b++) begin
      if (jc_in[b] != jc_in[b-1]) edges++;
    end
    w_legal = (edges <= 1);
    if (jc_in[N-1] || (jc_in == '0)) w_idx = BW'(ones);
    else                             w_idx = BW'(2*N - ones);
  end

  assign w_next_idx = (prev_q == LAST_IDX) ? '0 : prev_q + 1'b1;
  assign w_succ     = (w_idx == w_next_idx);
  assign w_rep      = (w_idx == prev_q);

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= ST_UNLOCKED;
      streak_q  <= '0;
      prev_q    <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      locked    <= 1'b0;
      wrap_cnt  <= '0;
    end else begin
      bin_valid <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      if (valid_in) begin
        if (!w_legal) begin
          illegal  <= 1'b1;
          locked   <= 1'b0;
          streak_q <= '0;
          state_q  <= ST_UNLOCKED;
        end else begin
          bin_out   <= w_idx;
          prev_q    <= w_idx;
          bin_valid <= 1'b1;
          case (state_q)
            ST_UNLOCKED: begin
              streak_q <= SW'(1);
              if (LOCK_CNT == 1) begin
                state_q <= ST_LOCKED;
                locked  <= 1'b1;
              end else begin
                state_q <= ST_TRACKING;
              end
            end
            ST_TRACKING: begin
              if (w_succ) begin
                if (int'(streak_q) + 1 >= LOCK_CNT) begin
                  streak_q <= SW'(LOCK_CNT);
                  state_q  <= ST_LOCKED;
                  locked   <= 1'b1;
                end else begin
                  streak_q <= streak_q + SW'(1);
                end
              end else begin
`ifdef JC_STALL_TOL_EN
                if (!w_rep) streak_q <= SW'(1);
`else
                streak_q <= SW'(1);
`endif
              end
            end
            ST_LOCKED: begin
              if (w_succ) begin
                if (w_idx == '0) wrap_cnt <= wrap_cnt + WRAP_W'(1);
`ifdef JC_STALL_TOL_EN
              end else if (w_rep) begin
                locked <= 1'b1;
`endif
              end else begin
                seq_err  <= 1'b1;
                locked   <= 1'b0;
                streak_q <= SW'(1);
                state_q  <= ST_TRACKING;
              end
            end
            default: begin
              state_q  <= ST_UNLOCKED;
              streak_q <= '0;
              locked   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_johnson_decoder_monitor.sv
`default_nettype none
// Scoreboard bench for johnson_decoder_monitor: a sequence-level reference model
// predicts every output cycle; a separate monitor pops and compares.
module tb_johnson_decoder_monitor;

  localparam int N        = 4;
  localparam int LOCK_CNT = 3;
  localparam int WRAP_W   = 8;
  localparam int BW       = $clog2(2*N);
  localparam int NS       = 2*N;

  typedef struct packed {
    logic [BW-1:0]     bin;
    logic              bv;
    logic              ill;
    logic              se;
    logic              lk;
    logic [WRAP_W-1:0] wrap;
  } exp_t;

  logic              clk = 1'b0;
  logic              clear = 1'b0;
  logic              valid_in = 1'b0;
  logic [N-1:0]      jc_in = '0;
  logic [BW-1:0]     bin_out;
  logic              bin_valid;
  logic              illegal;
  logic              seq_err;
  logic              locked;
  logic [WRAP_W-1:0] wrap_cnt;

  johnson_decoder_monitor #(.N(N), .LOCK_CNT(LOCK_CNT), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .clear(clear), .valid_in(valid_in), .jc_in(jc_in),
    .bin_out(bin_out), .bin_valid(bin_valid), .illegal(illegal),
    .seq_err(seq_err), .locked(locked), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [N-1:0] codes [NS];
  int   m_prev, m_streak, m_bin;
  bit   m_locked;
  int   m_wrap;
  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;
  bit done   = 1'b0;

  function automatic int code_index(input logic [N-1:0] c);
    for (int i = 0; i < NS; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_streak = 0; m_bin = 0; m_locked = 1'b0; m_wrap = 0;
  endtask

  task automatic step(input bit clr, input bit v, input logic [N-1:0] jc);
    exp_t e;
    int   idx;
    bit   succ, rep, stall_ok;
    @(negedge clk);
    clear = clr; valid_in = v; jc_in = jc;
    e = '0;
`ifdef JC_STALL_TOL_EN
    stall_ok = 1'b1;
`else
    stall_ok = 1'b0;
`endif
    if (clr) begin
      model_reset();
    end else if (v) begin
      idx = code_index(jc);
      if (idx < 0) begin
        e.ill = 1'b1; m_locked = 1'b0; m_streak = 0;
      end else begin
        succ = (idx == (m_prev + 1) % NS);
        rep  = (idx == m_prev);
        if (m_streak == 0) begin
          m_streak = 1; m_locked = (LOCK_CNT == 1);
        end else if (succ) begin
          if (m_locked && idx == 0) m_wrap = (m_wrap + 1) % (1 << WRAP_W);
          m_streak++;
          if (m_streak >= LOCK_CNT) m_locked = 1'b1;
        end else if (rep && stall_ok) begin
          // repeated code tolerated: nothing changes
        end else begin
          if (m_locked) e.se = 1'b1;
          m_locked = 1'b0; m_streak = 1;
        end
        m_prev = idx; m_bin = idx; e.bv = 1'b1;
      end
    end
    e.bin  = BW'(m_bin);
    e.lk   = m_locked;
    e.wrap = WRAP_W'(m_wrap);
    exp_q.push_back(e);
  endtask

  task automatic feed(input logic [N-1:0] jc);
    step(1'b0, 1'b1, jc);
  endtask

  // Monitor: outputs are registered, so each pushed expectation applies just after the next rising edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bin_out !== e.bin || bin_valid !== e.bv || illegal !== e.ill ||
            seq_err !== e.se || locked !== e.lk || wrap_cnt !== e.wrap)
          $display("FAIL outputs @%0t: got bin=%0d bv=%0b ill=%0b se=%0b lk=%0b wrap=%0d, want bin=%0d bv=%0b ill=%0b se=%0b lk=%0b wrap=%0d",
                   $time, bin_out, bin_valid, illegal, seq_err, locked, wrap_cnt,
                   e.bin, e.bv, e.ill, e.se, e.lk, e.wrap);
        else
          passed++;
      end
    end
  end

  initial begin : driver
    logic [N-1:0] c;
    int r;
    c = '0;
    for (int i = 0; i < NS; i++) begin
      codes[i] = c;
      c = {~c[0], c[N-1:1]};
    end
    model_reset();

    step(1'b1, 1'b1, 4'b1000);
    step(1'b1, 1'b1, 4'b1000);
    feed(4'b0000); feed(4'b1000); feed(4'b1100);
    feed(4'b1110); feed(4'b1111); feed(4'b0111); feed(4'b0011); feed(4'b0001);
    feed(4'b0000); feed(4'b1000); feed(4'b1100);
    step(1'b0, 1'b0, 4'b1010);
    feed(4'b1010);
    feed(4'b0000); feed(4'b1000); feed(4'b1100);
    feed(4'b1111); feed(4'b0111); feed(4'b0011);
    feed(4'b0001); feed(4'b0000); feed(4'b1000); feed(4'b1100);
    feed(4'b1110); feed(4'b1110); feed(4'b1111);
    step(1'b1, 1'b1, 4'b0111);
    step(1'b0, 1'b0, 4'b0000);

    // Long in-sequence run to exercise wrap_cnt across many wraps
    for (int i = 0; i < 20*NS; i++) feed(codes[i % NS]);

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 1'($urandom_range(0, 1)), N'($urandom));
      else if (r < 10) step(1'b0, 1'b0, N'($urandom));
      else if (r < 18) feed(N'($urandom_range(0, (1 << N) - 1)));
      else if (r < 24) feed(codes[m_prev]);
      else             feed(codes[(m_prev + 1) % NS]);
    end

    step(1'b0, 1'b0, '0);
    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/johnson_decoder_monitor.md
Name: johnson_decoder_monitor

Overview:
Receive-side companion to the team's Johnson-counter FSMs. It takes a sampled Johnson code word and decodes it to a binary state index. It also checks that the code is legal and that consecutive codes follow the Johnson sequence. It declares lock after a run of in-sequence codes and counts full sequence wraps. It sits downstream of any Johnson-coded counter or link and flags corruption or skipped states.

Parameters:
N, 4, Johnson code width in bits; the sequence has 2N states; N >= 2.
LOCK_CNT, 3, number of consecutive legal, in-sequence samples needed to assert locked; >= 1.
WRAP_W, 8, width of the wrap counter.
BW (localparam), $clog2(2N), width of the binary index output.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
clear  input  1  synchronous, active-high reset.
valid_in  input  1  jc_in is sampled on this edge.
jc_in  input  N  Johnson code word; the MSB is bit N-1.
bin_out  output  BW  decoded state index, 0..2N-1.
bin_valid  output  1  one-cycle pulse: bin_out was updated from a legal sample.
illegal  output  1  one-cycle pulse: the sample was not one of the 2N legal codes.
seq_err  output  1  one-cycle pulse: a legal sample broke the sequence while locked.
locked  output  1  level: sequence lock held.
wrap_cnt  output  WRAP_W  number of locked 2N-1 -> 0 transitions, modulo 2^WRAP_W.

Behaviour:
- Interface decision: one clock `clk`. `clear` is synchronous and active-high; it takes priority over everything else.
- Reset values:
  - bin_out=0, bin_valid=0, illegal=0, seq_err=0, locked=0, wrap_cnt=0.
  - FSM=UNLOCKED, streak=0, prev index=0.
- Code sequence is the shift-right sequence with the inverted LSB fed back into the MSB. For N=4: 0000,1000,1100,1110,1111,0111,0011,0001 -> indices 0..7.
- Legal code:
  - Form 1: k ones at the top followed by zeros, 0<=k<=N.
  - Form 2: j zeros at the top followed by ones, 1<=j<=N-1.
- Decode, with p = popcount(jc_in):
  - If MSB=1 or jc_in=0: index = p.
  - Otherwise: index = 2N - p.
- Latency: all outputs are registered; results appear one cycle after the sampling edge.
- valid_in=0: no state change; the pulse outputs are 0; bin_out, locked and wrap_cnt hold.
- Expected successor: (prev+1) mod 2N, so 2N-1 is followed by 0.
- FSM states:
  - UNLOCKED: no previous sample. A legal sample -> TRACKING with streak=1. If LOCK_CNT=1, go directly to LOCKED.
  - TRACKING: a legal sample equal to the successor increments streak; reaching LOCK_CNT -> LOCKED. A legal sample that is not the successor sets streak=1 and stays in TRACKING, with no seq_err.
  - LOCKED: a legal successor sample stays in LOCKED; if prev=2N-1 and index=0, wrap_cnt increments. A legal non-successor pulses seq_err, clears locked and goes to TRACKING with streak=1.
- Any illegal sample, in any state:
  - illegal=1, bin_valid=0, bin_out holds.
  - locked=0, streak=0, FSM -> UNLOCKED.
- A legal sample always updates bin_out and prev, and pulses bin_valid.
- locked rises in the same cycle as the bin_valid of the LOCK_CNT-th in-sequence sample.
- wrap_cnt is not cleared by errors; only clear resets it. It rolls over from all-ones to 0.
- clear with valid_in=1: the sample is discarded and all reset values apply.
- illegal and seq_err are never asserted together.

Optional Feature:
Macro JC_STALL_TOL_EN.
- Defined: a legal sample equal to prev (repeated code) is treated as in sequence. No seq_err, locked holds, streak is unchanged, and bin_valid still pulses.
- Not defined: a repeated code is a non-successor. In LOCKED it pulses seq_err and drops lock; in TRACKING it restarts streak at 1.

Test Plan:
1. N=4, LOCK_CNT=3: hold clear=1 for 2 cycles with valid_in=1 and jc_in=1000 -> all outputs 0 throughout; no bin_valid.
2. Feed 0000,1000,1100 -> bin_out 0,1,2 with bin_valid each cycle; locked=1 together with index 2; no illegal or seq_err.
3. Continue 1110..0001, then 0000 -> bin_out 3..7, then 0; wrap_cnt 0->1 on the 0 sample; locked stays 1.
4. While locked at index 2, feed 1010 -> illegal=1 for one cycle, locked=0, bin_out stays 2. Then 0000,1000,1100 -> locked reasserts on the third sample.
5. While locked at index 2 (1100), feed 1111 -> seq_err=1, locked=0, bin_out=4. Then 0111,0011 -> locked=1 on 0011 (streak reaches 3).
6. While locked, repeat 1110 twice -> without JC_STALL_TOL_EN: seq_err on the second and locked=0. With JC_STALL_TOL_EN: no seq_err and locked stays 1. Separately, assert clear while locked -> wrap_cnt=0 and locked=0 the next cycle.
